// File: rtl/msg_display_seq.sv
// Message display sequencer: latches a bank word on request, holds it, and scans digits.
// Optional blink support is compiled in when MSG_BLINK_EN is defined.
module msg_display_seq #(
    parameter int unsigned NUM_MSG      = 4,
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned CODE_W       = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned HOLD_CYCLES  = 50000000,
    parameter int unsigned BLINK_CYCLES = 25000000,
    parameter logic [CODE_W-1:0] BLANK_CODE = {CODE_W{1'b1}},
    localparam int unsigned SEL_W       = $clog2(NUM_MSG)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_MSG*DIGITS*CODE_W-1:0]   msg_bank,
    input  logic                               req_valid,
    input  logic [SEL_W-1:0]                   req_sel,
    input  logic                               req_blink,
    output logic                               req_ready,
    input  logic                               clr,
    output logic [CODE_W-1:0]                  digit_code,
    output logic [DIGITS-1:0]                  digit_en,
    output logic                               busy,
    output logic                               sel_err
);

    localparam int unsigned WORD_W = DIGITS * CODE_W;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [WORD_W-1:0] BLANK_WORD = {DIGITS{BLANK_CODE}};

    typedef enum logic {StIdle, StHold} state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]    scan_idx_q, scan_idx_d;
    logic [DIGITS-1:0]   digit_en_q, digit_en_d;
    logic [CODE_W-1:0]   digit_code_q, digit_code_d;
    logic                sel_err_q, sel_err_d;
    logic                accept;
    logic                sel_hit;
    logic [WORD_W-1:0]   sel_word;
    logic [CODE_W-1:0]   scan_code;
    logic                show;

    always_comb begin
        sel_word = BLANK_WORD;
        sel_hit  = 1'b0;
        for (int i = 0; i < NUM_MSG; i++) begin
            if (req_sel == SEL_W'(i)) begin
                sel_word = msg_bank[i*WORD_W +: WORD_W];
                sel_hit  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        hold_d    = hold_q;
        sel_err_d = 1'b0;
        req_ready = (state_q == StIdle) && !clr;
        accept    = req_valid && req_ready;
        if (clr) begin
            state_d = StIdle;
            word_d  = BLANK_WORD;
            hold_d  = '0;
        end else if (accept) begin
            state_d   = StHold;
            word_d    = sel_word;
            hold_d    = '0;
            sel_err_d = !sel_hit;
        end else if (state_q == StHold) begin
            if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                state_d = StIdle;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    // Scan runs free; outputs use the next index so enable and code move together.
    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == IDX_W'(DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
        end
        scan_code = BLANK_CODE;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx_d == IDX_W'(i)) begin
                scan_code = word_q[i*CODE_W +: CODE_W];
            end
        end
    end

`ifdef MSG_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic               blink_flag_q, blink_flag_d;
    logic               blink_on_q, blink_on_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;

    always_comb begin
        blink_flag_d = blink_flag_q;
        blink_on_d   = blink_on_q;
        blink_cnt_d  = blink_cnt_q;
        if (clr) begin
            blink_flag_d = 1'b0;
            blink_on_d   = 1'b1;
            blink_cnt_d  = '0;
        end else if (accept) begin
            blink_flag_d = req_blink;
            blink_on_d   = 1'b1;
            blink_cnt_d  = '0;
        end else if (blink_flag_q) begin
            if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
                blink_cnt_d = '0;
                blink_on_d  = !blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
        show = blink_on_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_flag_q <= 1'b0;
            blink_on_q   <= 1'b1;
            blink_cnt_q  <= '0;
        end else begin
            blink_flag_q <= blink_flag_d;
            blink_on_q   <= blink_on_d;
            blink_cnt_q  <= blink_cnt_d;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = req_blink;
    assign show = 1'b1;
`endif

    always_comb begin
        digit_en_d   = show ? (DIGITS'(1) << scan_idx_d) : '0;
        digit_code_d = show ? scan_code : BLANK_CODE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            word_q       <= BLANK_WORD;
            hold_q       <= '0;
            scan_cnt_q   <= '0;
            scan_idx_q   <= '0;
            digit_en_q   <= DIGITS'(1);
            digit_code_q <= BLANK_CODE;
            sel_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            hold_q       <= hold_d;
            scan_cnt_q   <= scan_cnt_d;
            scan_idx_q   <= scan_idx_d;
            digit_en_q   <= digit_en_d;
            digit_code_q <= digit_code_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign digit_en   = digit_en_q;
    assign digit_code = digit_code_q;
    assign busy       = (state_q == StHold);
    assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_msg_display_seq.sv
// Self-checking bench for msg_display_seq against a cycle-count reference model.
// Blink checks are included when MSG_BLINK_EN is defined.
module tb_msg_display_seq;

    localparam int NUM_MSG = 4;
    localparam int DIGITS  = 4;
    localparam int CODE_W  = 4;
    localparam int SCAN    = 4;
    localparam int HOLD    = 10;
    localparam int BLINK   = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] msg_bank = {16'h1034, 16'h6077, 16'h7856, 16'h1944};
    logic        req_valid, req_blink, clr;
    logic [1:0]  req_sel;
    logic        req_ready, busy, sel_err;
    logic [3:0]  digit_code, digit_en;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int          m_edges;
    logic [15:0] m_word, m_shown;
    int          m_left;
    bit          m_bflag;
    int          m_bage;

    msg_display_seq #(
        .NUM_MSG(NUM_MSG), .DIGITS(DIGITS), .CODE_W(CODE_W), .SCAN_DIV(SCAN),
        .HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK), .BLANK_CODE(4'hF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .msg_bank(msg_bank), .req_valid(req_valid),
        .req_sel(req_sel), .req_blink(req_blink), .req_ready(req_ready), .clr(clr),
        .digit_code(digit_code), .digit_en(digit_en), .busy(busy), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_edges = 0;
        m_word  = 16'hFFFF;
        m_shown = 16'hFFFF;
        m_left  = 0;
        m_bflag = 0;
        m_bage  = 0;
    endtask

    task automatic model_edge(output bit acc);
        int s;
        acc     = req_valid && (m_left == 0) && !clr;
        m_shown = m_word;
        m_edges++;
        m_bage++;
        if (clr) begin
            m_word  = 16'hFFFF;
            m_left  = 0;
            m_bflag = 0;
            m_bage  = 0;
        end else if (acc) begin
            s       = int'(req_sel);
            m_word  = msg_bank[s*16 +: 16];
            m_left  = HOLD;
            m_bflag = req_blink;
            m_bage  = 0;
        end else if (m_left > 0) begin
            m_left--;
        end
    endtask

    task automatic check_all();
        int idx;
        bit off;
        idx = (m_edges / SCAN) % DIGITS;
        off = 0;
`ifdef MSG_BLINK_EN
        off = m_bflag && (((m_bage / BLINK) % 2) == 1);
`endif
        chk("digit_en", 32'(digit_en), off ? 32'd0 : 32'(1 << idx));
        chk("digit_code", 32'(digit_code), off ? 32'hF : 32'(m_shown[idx*4 +: 4]));
        chk("busy", 32'(busy), 32'(m_left > 0));
        chk("req_ready", 32'(req_ready), 32'((m_left == 0) && !clr));
        chk("sel_err", 32'(sel_err), 32'd0);
    endtask

    task automatic cycle(output bit acc);
        @(posedge clk);
        model_edge(acc);
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    task automatic wait_accept(output int waited);
        bit acc;
        bit got;
        got    = 0;
        waited = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            cycle(acc);
            waited++;
            got = acc;
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_en"}, 32'(digit_en), 32'd1);
        chk({tag, "_code"}, 32'(digit_code), 32'hF);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_serr"}, 32'(sel_err), 32'd0);
    endtask

    initial begin
        logic [3:0] stop_codes [4];
        int waited;
        int idx;
        bit acc;
        stop_codes = '{4'h6, 4'h5, 4'h8, 4'h7};

        rst_n = 1'b0; req_valid = 1'b0; req_sel = '0; req_blink = 1'b0; clr = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Blank scan after reset
        run(16);

        // STOP word: digit codes over one full refresh
        req_valid = 1'b1; req_sel = 2'd1;
        wait_accept(waited);
        for (int j = 0; j < 16; j++) begin
            cycle(acc);
            idx = (m_edges / SCAN) % DIGITS;
            chk("stop_code", 32'(digit_code), 32'(stop_codes[idx]));
        end
        run(4);

        // Back-to-back: second request held through HOLD
        req_valid = 1'b1; req_sel = 2'd0;
        wait_accept(waited);
        req_valid = 1'b1; req_sel = 2'd2;
        wait_accept(waited);
        chk("b2b_spacing", 32'(waited), 32'(HOLD + 1));
        run(16);

        // clr wins over a simultaneous request during HOLD
        req_valid = 1'b1; req_sel = 2'd3;
        wait_accept(waited);
        run(3);
        clr = 1'b1; req_valid = 1'b1; req_sel = 2'd0;
        #1;
        chk("clr_ready_low", 32'(req_ready), 32'd0);
        cycle(acc);
        chk("clr_not_accepted", 32'(acc), 32'd0);
        clr = 1'b0;
        cycle(acc);
        chk("after_clr_accept", 32'(acc), 32'd1);
        req_valid = 1'b0;
        run(14);

`ifdef MSG_BLINK_EN
        // Blink: 8 on, 8 off, continuing past HOLD
        req_valid = 1'b1; req_sel = 2'd3; req_blink = 1'b1;
        wait_accept(waited);
        req_blink = 1'b0;
        for (int j = 1; j <= 24; j++) begin
            cycle(acc);
            if (j >= 8 && j < 16) chk("blink_off", 32'(digit_en), 32'd0);
            else chk("blink_on_nonzero", 32'(digit_en != 0), 32'd1);
        end
        clr = 1'b1;
        cycle(acc);
        clr = 1'b0;
`endif

        // Randomized requests and clears
        for (int i = 0; i < 400; i++) begin
            if (!req_valid && ($urandom % 3 == 0)) begin
                req_valid = 1'b1;
                req_sel   = 2'($urandom % NUM_MSG);
                req_blink = 1'($urandom % 2);
            end
            clr = ($urandom % 20 == 0);
            cycle(acc);
            if (acc) req_valid = 1'b0;
        end
        clr = 1'b0; req_valid = 1'b0; req_blink = 1'b0;
        run(2);

        // Async reset mid-HOLD, between edges
        req_valid = 1'b1; req_sel = 2'd1;
        wait_accept(waited);
        run(3);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/msg_display_seq.md
# msg_display_seq

Parametrised successor to the fixed four-word display selector. It accepts a message request through a valid/ready handshake and latches the selected word from a parent-supplied message bank. It holds the word for a guaranteed minimum time and time-multiplexes it digit by digit onto a shared 7-segment decoder input. It sits between the access-control FSM, which issues FULL/STOP/PASS/FAIL requests, and the segment decoder and digit drivers.

## Interface
- NUM_MSG, 4, number of words in the message bank (≥2)
- DIGITS, 4, digits per word (≥1)
- CODE_W, 4, bits per digit code
- SCAN_DIV, 50000, clocks each digit stays enabled (≥1)
- HOLD_CYCLES, 50000000, minimum clocks an accepted word is shown before the next request is accepted (≥1)
- BLINK_CYCLES, 25000000, clocks per blink half-period (used only with MSG_BLINK_EN)
- BLANK_CODE, 4'hF, digit code the decoder renders as dark
- SEL_W, $clog2(NUM_MSG), select width (derived)

Ports:
- clk  in  1  system clock; every register is rising-edge
- rst_n  in  1  asynchronous active-low reset
- msg_bank  in  NUM_MSG*DIGITS*CODE_W  word i at bits [(i+1)*DIGITS*CODE_W-1 : i*DIGITS*CODE_W]
- req_valid  in  1  request present
- req_sel  in  SEL_W  requested word index
- req_blink  in  1  blink the requested word (ignored without MSG_BLINK_EN)
- req_ready  out  1  request accepted when valid && ready at a rising edge
- clr  in  1  synchronous blank-and-abort
- digit_code  out  CODE_W  code for the currently enabled digit, registered
- digit_en  out  DIGITS  one-hot active-high digit enable, registered
- busy  out  1  hold timer running
- sel_err  out  1  one-cycle pulse: accepted req_sel ≥ NUM_MSG

## Operation
- Two states:
  - IDLE: req_ready=1 unless clr=1.
  - HOLD: req_ready=0, busy=1.
- Reset values:
  - State IDLE; word register all BLANK_CODE; scan index 0; scan and hold counters 0.
  - digit_en=1 (digit 0); digit_code=BLANK_CODE; req_ready=1; busy=0; sel_err=0.
  - Blink phase is "on" and the blink flag is cleared.
- IDLE→HOLD on an accepted request:
  - Load word req_sel into the word register.
  - If req_sel ≥ NUM_MSG: load all BLANK_CODE and pulse sel_err.
  - Zero the hold counter.
- HOLD→IDLE when the hold counter reaches HOLD_CYCLES-1. The word stays displayed in IDLE until replaced or cleared.
- clr, in any state:
  - Next edge: word=BLANK, state IDLE, hold counter 0, blink flag cleared.
  - clr has priority over a simultaneous request; that request is not accepted (req_ready is forced to 0).
- Requests during HOLD are not accepted. The source keeps req_valid high, with req_sel stable, until ready.
- Scan:
  - The scan counter runs continuously from 0 to SCAN_DIV-1.
  - On wrap, the scan index advances; it wraps from DIGITS-1 to 0.
  - Scanning is never reset by requests or clr.
- Digit i shows word bits [(i+1)*CODE_W-1 : i*CODE_W]. Digit DIGITS-1 is the leftmost display position.
- Output register per edge: digit_en = one-hot(index); digit_code = word digit[index].

## Timing
- Request accepted at edge k:
  - Word register and busy are updated at edge k.
  - digit_code reflects the new word from edge k+1.
- busy is high for exactly HOLD_CYCLES clocks. req_ready rises in the cycle after busy falls, so back-to-back requests are spaced HOLD_CYCLES+1 clocks at acceptance.
- Digit dwell is exactly SCAN_DIV clocks. Full refresh period is DIGITS*SCAN_DIV clocks.
- digit_en changes in the same edge as digit_code, with no overlap.
- Async reset takes effect immediately, mid-hold or mid-scan. Outputs take reset values without a clock.

## Configuration
- MSG_BLINK_EN defined:
  - An accepted request latches req_blink into the blink flag and restarts the blink counter in the "on" phase.
  - While the flag is set, each half-period toggles the phase.
  - In the "off" phase, digit_en=0 and digit_code=BLANK_CODE.
  - The scan keeps running during "off". Blink continues after HOLD ends until a new request or clr.
- MSG_BLINK_EN undefined:
  - No blink counter or flag is built; req_blink is unused.
  - digit_en is always one-hot.

## Test plan
Parameters: NUM_MSG=4, DIGITS=4, SCAN_DIV=4, HOLD_CYCLES=10, BLINK_CYCLES=8, msg_bank={FAIL 16'h1034, PASS 16'h6077, STOP 16'h7856, FULL 16'h1944}.
- Reset release with no request → digit_code=4'hF on every digit; digit_en sequence 0001,0010,0100,1000, each for 4 clocks; req_ready=1.
- req_sel=1 accepted → over one 16-clock refresh, digit_code: digit0=6, digit1=5, digit2=8, digit3=7; busy high for 10 clocks; req_ready returns on the 11th.
- req_sel=2 held valid during HOLD of sel=0 → not accepted until req_ready=1; accepted exactly 11 clocks after the first acceptance; PASS codes follow.
- clr and req_valid in the same cycle during HOLD → word blank, state IDLE, req_ready=0 that cycle, request accepted on the next edge.
- Async rst_n low mid-HOLD, between clock edges → outputs immediately take reset values; busy=0.
- MSG_BLINK_EN with req_blink=1, sel=3 → digit_en alternates: 8 clocks scanning, 8 clocks all-zero; repeats past the end of HOLD.
